// File: rtl/triangle_setup.sv
// Triangle setup stage: signed area, winding fix-up, zero-area culling and a
// serial restoring divide producing 2^FRAC_BITS / |2*area| for the rasterizer.
module triangle_setup #(
  parameter int FRAC_BITS = 24
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_v1x,
  input  logic [8:0]  in_v2x,
  input  logic [8:0]  in_v3x,
  input  logic [7:0]  in_v1y,
  input  logic [7:0]  in_v2y,
  input  logic [7:0]  in_v3y,
  input  logic [15:0] in_z1,
  input  logic [15:0] in_z2,
  input  logic [15:0] in_z3,
  input  logic [7:0]  in_color,
  output logic        triangle_valid,
  input  logic        triangle_ready,
  output logic [8:0]  v1x,
  output logic [8:0]  v2x,
  output logic [8:0]  v3x,
  output logic [7:0]  v1y,
  output logic [7:0]  v2y,
  output logic [7:0]  v3y,
  output logic [15:0] z1,
  output logic [15:0] z2,
  output logic [15:0] z3,
  output logic [7:0]  color,
  output logic [31:0] inv_area,
  output logic        cull_pulse,
  output logic [15:0] tri_count,
  output logic [15:0] cull_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and data is held while valid && !ready.

  typedef enum logic [1:0] {IDLE, AREA, DIV, OUT} state_t;

  state_t             state;
  logic [17:0]        area_abs;
  logic [19:0]        rem;
  logic [31:0]        quo;
  logic [5:0]         bit_cnt;

  logic signed [20:0] area_s;
  logic               div_bit_in;
  logic [19:0]        rem_sh;
  logic               fits;
  logic [19:0]        rem_nx;
  logic [31:0]        quo_nx;

  // Twice the signed area; the 21-bit range holds every 9x8-bit vertex set.
  always_comb begin
    area_s = $signed({12'd0, v1x}) * ($signed({13'd0, v2y}) - $signed({13'd0, v3y}))
           + $signed({12'd0, v2x}) * ($signed({13'd0, v3y}) - $signed({13'd0, v1y}))
           + $signed({12'd0, v3x}) * ($signed({13'd0, v1y}) - $signed({13'd0, v2y}));
  end

  // Dividend 2^FRAC_BITS has a single set bit, consumed first (MSB first).
  always_comb begin
    div_bit_in = (bit_cnt == 6'(FRAC_BITS));
    rem_sh     = {rem[18:0], div_bit_in};
    fits       = (rem_sh >= {2'b00, area_abs});
    rem_nx     = fits ? (rem_sh - {2'b00, area_abs}) : rem_sh;
    quo_nx     = {quo[30:0], fits};
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      triangle_valid <= 1'b0;
      cull_pulse     <= 1'b0;
      v1x            <= '0;
      v2x            <= '0;
      v3x            <= '0;
      v1y            <= '0;
      v2y            <= '0;
      v3y            <= '0;
      z1             <= '0;
      z2             <= '0;
      z3             <= '0;
      color          <= '0;
      inv_area       <= '0;
      tri_count      <= '0;
      cull_count     <= '0;
      area_abs       <= '0;
      rem            <= '0;
      quo            <= '0;
      bit_cnt        <= '0;
    end else begin
      cull_pulse <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            v1x       <= in_v1x;
            v2x       <= in_v2x;
            v3x       <= in_v3x;
            v1y       <= in_v1y;
            v2y       <= in_v2y;
            v3y       <= in_v3y;
            z1        <= in_z1;
            z2        <= in_z2;
            z3        <= in_z3;
            color     <= in_color;
            tri_count <= tri_count + 16'd1;
            in_ready  <= 1'b0;
            state     <= AREA;
          end
        end
        AREA: begin
          if (area_s == 21'sd0) begin
            cull_pulse <= 1'b1;
            cull_count <= cull_count + 16'd1;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end else begin
            area_abs <= 18'((area_s < 0) ? -area_s : area_s);
            // Clockwise input: swap vertices 2 and 3 so the emitted area is positive.
            if (area_s < 0) begin
              v2x <= v3x;
              v3x <= v2x;
              v2y <= v3y;
              v3y <= v2y;
              z2  <= z3;
              z3  <= z2;
            end
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= 6'(FRAC_BITS);
            state   <= DIV;
          end
        end
        DIV: begin
          rem     <= rem_nx;
          quo     <= quo_nx;
          bit_cnt <= bit_cnt - 6'd1;
          if (bit_cnt == 6'd0) begin
            inv_area       <= quo_nx;
            triangle_valid <= 1'b1;
            state          <= OUT;
          end
        end
        OUT: begin
          if (triangle_ready) begin
            triangle_valid <= 1'b0;
            in_ready       <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: hand-computed areas, reciprocals,
// winding swap, culling, backpressure and asynchronous reset mid-divide.
module tb_triangle_setup;

  localparam int FRAC_BITS = 24;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_v1x, in_v2x, in_v3x;
  logic [7:0]  in_v1y, in_v2y, in_v3y;
  logic [15:0] in_z1, in_z2, in_z3;
  logic [7:0]  in_color;
  logic        triangle_valid;
  logic        triangle_ready;
  logic [8:0]  v1x, v2x, v3x;
  logic [7:0]  v1y, v2y, v3y;
  logic [15:0] z1, z2, z3;
  logic [7:0]  color;
  logic [31:0] inv_area;
  logic        cull_pulse;
  logic [15:0] tri_count;
  logic [15:0] cull_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_tri = '0;
  logic [15:0] exp_cull = '0;

  triangle_setup #(.FRAC_BITS(FRAC_BITS)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_v1x(in_v1x), .in_v2x(in_v2x), .in_v3x(in_v3x),
    .in_v1y(in_v1y), .in_v2y(in_v2y), .in_v3y(in_v3y),
    .in_z1(in_z1), .in_z2(in_z2), .in_z3(in_z3), .in_color(in_color),
    .triangle_valid(triangle_valid), .triangle_ready(triangle_ready),
    .v1x(v1x), .v2x(v2x), .v3x(v3x), .v1y(v1y), .v2y(v2y), .v3y(v3y),
    .z1(z1), .z2(z2), .z3(z3), .color(color), .inv_area(inv_area),
    .cull_pulse(cull_pulse), .tri_count(tri_count), .cull_count(cull_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [138:0] outs();
    return {v1x, v1y, v2x, v2y, v3x, v3y, z1, z2, z3, color, inv_area};
  endfunction

  task automatic scramble_inputs();
    in_v1x = 9'($urandom); in_v2x = 9'($urandom); in_v3x = 9'($urandom);
    in_v1y = 8'($urandom); in_v2y = 8'($urandom); in_v3y = 8'($urandom);
    in_z1 = 16'($urandom); in_z2 = 16'($urandom); in_z3 = 16'($urandom);
    in_color = 8'($urandom);
  endtask

  // Driver: present one triangle, wait (bounded) for in_ready, return #1 after the accept edge.
  task automatic send_tri(input logic [8:0] x1, input logic [7:0] y1,
                          input logic [8:0] x2, input logic [7:0] y2,
                          input logic [8:0] x3, input logic [7:0] y3,
                          input logic [15:0] za, input logic [15:0] zb,
                          input logic [15:0] zc, input logic [7:0] col);
    int w = 0;
    in_v1x = x1; in_v1y = y1; in_v2x = x2; in_v2y = y2; in_v3x = x3; in_v3y = y3;
    in_z1 = za; in_z2 = zb; in_z3 = zc; in_color = col;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    exp_tri = exp_tri + 16'd1;
  endtask

  // Latency counted as the index of the first edge (accept edge = 0) that samples triangle_valid=1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!triangle_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    triangle_ready = 1'b1;
    @(posedge clk); #1;
    triangle_ready = 1'b0;
    checks++;
    if (triangle_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL consume: valid=%b in_ready=%b required 0/1", triangle_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; triangle_ready = 1'b0;
    scramble_inputs();
    #2;
    checks++;
    if ({outs(), triangle_valid, cull_pulse, tri_count, cull_count, in_ready} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {outs(), triangle_valid, cull_pulse, tri_count, cull_count, in_ready});
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    send_tri(9'd40, 8'd20, 9'd140, 8'd120, 9'd40, 8'd120, 16'd50, 16'd50, 16'd50, 8'hE0);
    wait_valid(lat);
    checks++;
    if (lat !== FRAC_BITS + 3) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, FRAC_BITS + 3); end
    checks++;
    if (inv_area !== 32'h0000068D) begin errors++; $display("FAIL basic_inv_area: got %h required 0000068d", inv_area); end
    checks++;
    if ({v1x, v1y, v2x, v2y, v3x, v3y} !== {9'd40, 8'd20, 9'd140, 8'd120, 9'd40, 8'd120}) begin
      errors++; $display("FAIL basic_vertices: got %h", {v1x, v1y, v2x, v2y, v3x, v3y});
    end
    checks++;
    if ({z1, z2, z3, color} !== {16'd50, 16'd50, 16'd50, 8'hE0}) begin
      errors++; $display("FAIL basic_z_color: got %h", {z1, z2, z3, color});
    end
    checks++;
    if (tri_count !== 16'd1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_count_ready: tri_count=%0d in_ready=%b required 1/0", tri_count, in_ready);
    end
    consume();
  endtask

  task automatic test_swap();
    int lat;
    send_tri(9'd140, 8'd20, 9'd90, 8'd70, 9'd190, 8'd70, 16'd100, 16'd200, 16'd300, 8'h1C);
    wait_valid(lat);
    checks++;
    if (lat !== FRAC_BITS + 3) begin errors++; $display("FAIL swap_latency: got %0d required %0d", lat, FRAC_BITS + 3); end
    checks++;
    if (inv_area !== 32'h00000D1B) begin errors++; $display("FAIL swap_inv_area: got %h required 00000d1b", inv_area); end
    checks++;
    if ({v1x, v1y, v2x, v2y, v3x, v3y} !== {9'd140, 8'd20, 9'd190, 8'd70, 9'd90, 8'd70}) begin
      errors++; $display("FAIL swap_vertices: got %h", {v1x, v1y, v2x, v2y, v3x, v3y});
    end
    checks++;
    if ({z1, z2, z3, color} !== {16'd100, 16'd300, 16'd200, 8'h1C}) begin
      errors++; $display("FAIL swap_z_color: got %h", {z1, z2, z3, color});
    end
    consume();
  endtask

  task automatic test_cull();
    int seen = 0;
    send_tri(9'd0, 8'd0, 9'd10, 8'd10, 9'd20, 8'd20, 16'd1, 16'd2, 16'd3, 8'h03);
    exp_cull = exp_cull + 16'd1;
    checks++;
    if (cull_pulse !== 1'b0) begin errors++; $display("FAIL cull_early: cull_pulse=%b required 0", cull_pulse); end
    @(posedge clk); #1;
    checks++;
    if (cull_pulse !== 1'b1 || cull_count !== exp_cull || tri_count !== exp_tri) begin
      errors++; $display("FAIL cull_pulse: pulse=%b cull=%0d tri=%0d required 1/%0d/%0d", cull_pulse, cull_count, tri_count, exp_cull, exp_tri);
    end
    @(posedge clk); #1;
    checks++;
    if (cull_pulse !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL cull_after: pulse=%b in_ready=%b required 0/1", cull_pulse, in_ready);
    end
    repeat (30) begin @(posedge clk); #1; if (triangle_valid || cull_pulse) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL cull_no_output: %0d cycles with valid/pulse required 0", seen); end
  endtask

  task automatic test_area_extremes();
    int lat;
    send_tri(9'd0, 8'd0, 9'd1, 8'd0, 9'd0, 8'd1, 16'd7, 16'd8, 16'd9, 8'hFF);
    wait_valid(lat);
    checks++;
    if (inv_area !== 32'h01000000) begin errors++; $display("FAIL min_area_inv: got %h required 01000000", inv_area); end
    consume();
    send_tri(9'd0, 8'd0, 9'd511, 8'd0, 9'd0, 8'd255, 16'd7, 16'd8, 16'd9, 8'hFF);
    wait_valid(lat);
    checks++;
    if (inv_area !== 32'h00000080) begin errors++; $display("FAIL max_area_inv: got %h required 00000080", inv_area); end
    checks++;
    if (lat !== FRAC_BITS + 3) begin errors++; $display("FAIL max_area_latency: got %0d required %0d", lat, FRAC_BITS + 3); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [138:0] snap;
    send_tri(9'd0, 8'd0, 9'd100, 8'd0, 9'd0, 8'd50, 16'd1, 16'd2, 16'd3, 8'h5A);
    wait_valid(lat);
    snap = outs();
    checks++;
    if (inv_area !== 32'h00000D1B) begin errors++; $display("FAIL bp_inv_area: got %h required 00000d1b", inv_area); end
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (outs() !== snap || triangle_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid=%b in_ready=%b outs=%h required 1/0/%h", i, triangle_valid, in_ready, outs(), snap);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (tri_count !== exp_tri) begin errors++; $display("FAIL bp_ignored_input: tri_count=%0d required %0d", tri_count, exp_tri); end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int seen = 0;
    send_tri(9'd40, 8'd20, 9'd140, 8'd120, 9'd40, 8'd120, 16'd5, 16'd6, 16'd7, 8'h11);
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    checks++;
    if ({outs(), triangle_valid, cull_pulse, tri_count, cull_count, in_ready} !== '0) begin
      errors++; $display("FAIL mid_div_reset: got %h required 0", {outs(), triangle_valid, cull_pulse, tri_count, cull_count, in_ready});
    end
    exp_tri = '0; exp_cull = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (triangle_valid) seen++; end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_quiet: valid cycles=%0d in_ready=%b required 0/1", seen, in_ready);
    end
    send_tri(9'd140, 8'd20, 9'd90, 8'd70, 9'd190, 8'd70, 16'd10, 16'd20, 16'd30, 8'h22);
    wait_valid(lat);
    checks++;
    if (lat !== FRAC_BITS + 3 || inv_area !== 32'h00000D1B || tri_count !== 16'd1) begin
      errors++; $display("FAIL post_reset_tri: lat=%0d inv=%h tri=%0d required %0d/00000d1b/1", lat, inv_area, tri_count, FRAC_BITS + 3);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_cull();
    test_area_extremes();
    test_backpressure();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
